// File: rtl/td4_mem_dump_tx_if.sv
// Bus between the TD4 program-memory dumper and its surroundings: the dump
// request, the memory read port and the serial/status outputs.
interface td4_mem_dump_tx_if;
  logic       start;
  logic [3:0] mem_address;
  logic [3:0] opcode_in;
  logic [3:0] immediate_in;
  logic       tx;
  logic       busy;
  logic       done;

  // The dumper: drives the read address and the serial line.
  modport master (
    input  start,
    input  opcode_in,
    input  immediate_in,
    output mem_address,
    output tx,
    output busy,
    output done
  );

  // The environment: program memory plus whoever requests and receives a dump.
  modport slave (
    output start,
    output opcode_in,
    output immediate_in,
    input  mem_address,
    input  tx,
    input  busy,
    input  done
  );
endinterface

// File: rtl/td4_mem_dump_tx.sv
// Serial program-memory dumper for the TD4 tile.
// Sends header 0xA5, the 16 memory bytes {immediate, opcode} and an 8-bit
// additive checksum of the memory bytes, each as an 8N1 frame, LSB first.
// Every frame after the header is preceded by two idle-high gap cycles.
module td4_mem_dump_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  td4_mem_dump_tx_if.master  bus
);

  localparam int unsigned CntW    = 12;
  localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]      Header  = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StFetch,
    StLoad,
    StLoadCk,
    StFinish
  } state_e;

  // Which kind of frame is currently in flight; decides where STOP goes next.
  typedef enum logic [1:0] {
    KindHdr,
    KindMem,
    KindCk
  } kind_e;

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      acc_q, acc_d;
  logic [3:0]      addr_q, addr_d;
  logic            last_q, last_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic       bit_end;
  logic [7:0] mem_byte;

  assign bit_end  = (cnt_q == BitLast);
  assign mem_byte = {bus.immediate_in, bus.opcode_in};

  assign bus.mem_address = addr_q;
  assign bus.tx          = tx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

  // State and output registers; reset truncates any frame and clears all counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      kind_q    <= KindHdr;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      acc_q     <= '0;
      addr_q    <= '0;
      last_q    <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: bit timing, frame sequencing and memory fetch.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    addr_d    = addr_q;
    last_d    = last_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.start) begin
          shift_d   = Header;
          kind_d    = KindHdr;
          acc_d     = '0;
          addr_d    = '0;
          last_d    = 1'b0;
          bit_idx_d = '0;
          state_d   = StStart;
        end
      end

      StStart: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (bit_end) begin
          cnt_d     = '0;
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          case (kind_q)
            KindHdr: state_d = StFetch;
            KindMem: state_d = last_q ? StLoadCk : StFetch;
            KindCk: begin
              addr_d  = '0;
              state_d = StFinish;
            end
            default: state_d = StFinish;
          endcase
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StFetch: begin
        state_d = StLoad;
      end

      // Memory data is sampled here, one cycle after the address was presented.
      StLoad: begin
        shift_d = mem_byte;
        acc_d   = acc_q + mem_byte;
        kind_d  = KindMem;
        // Address 15 saturates and flags the checksum as the next frame.
        if (addr_q == 4'hF) begin
          last_d = 1'b1;
        end else begin
          addr_d = addr_q + 4'd1;
        end
        state_d = StStart;
      end

      // Two-cycle gap matching FETCH+LOAD; the checksum is latched on the second.
      StLoadCk: begin
        if (cnt_q == '0) begin
          cnt_d = CntW'(1);
        end else begin
          cnt_d   = '0;
          shift_d = acc_q;
          kind_d  = KindCk;
          state_d = StStart;
        end
      end

      StFinish: begin
        last_d  = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // Output logic: computed from the next state so the registered outputs
  // line up with the state they describe.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    if ((state_d == StIdle) || (state_d == StFinish)) begin
      busy_d = 1'b0;
    end
    if (state_d == StFinish) begin
      done_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_td4_mem_dump_tx.sv
// Bench for td4_mem_dump_tx: a reference model pushes the expected byte
// stream of each dump into a scoreboard queue; an independent UART receiver
// decodes the serial line and pops/compares every received byte.
module tb_td4_mem_dump_tx;
  localparam int unsigned C          = 4;
  localparam int unsigned DumpCycles = 180 * C + 35;

  logic clk = 1'b0;
  logic rst;

  td4_mem_dump_tx_if bus ();

  logic [3:0] mem_op  [16];
  logic [3:0] mem_imm [16];

  assign bus.opcode_in    = mem_op[bus.mem_address];
  assign bus.immediate_in = mem_imm[bus.mem_address];

  td4_mem_dump_tx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          rx_n  = 0;
  logic [7:0]  exp_q [$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART receiver + scoreboard checker, sampling mid-bit on falling edges.
  logic        rx_on   = 1'b0;
  int unsigned rx_cnt  = 0;
  logic [7:0]  rx_byte = '0;
  logic [7:0]  rx_exp;

  initial forever begin
    @(negedge clk);
    if (bus.done === 1'b1) begin
      chk("busy_low_at_done", {31'b0, bus.busy}, 32'd0);
    end
    if (rst) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (bus.tx === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == C / 2) begin
        chk("start_bit", {31'b0, bus.tx}, 32'd0);
      end else if ((rx_cnt % C == C / 2) && (rx_cnt >= C) && (rx_cnt < 9 * C)) begin
        rx_byte[rx_cnt / C - 1] = bus.tx;
      end else if (rx_cnt == 9 * C + C / 2) begin
        chk("stop_bit", {31'b0, bus.tx}, 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte: got %0h, expected no byte (cycle %0d)", rx_byte, cyc);
        end else begin
          rx_exp = exp_q.pop_front();
          chk("rx_byte", {24'b0, rx_byte}, {24'b0, rx_exp});
        end
        rx_n++;
        rx_on = 1'b0;
      end
    end
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 0 ramp (0x11*i), 1 all zero, 2 all 0x01, otherwise random.
  task automatic load_mem(input int mode);
    logic [7:0] v;
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0:       v = 8'(8'h11 * i);
        1:       v = 8'h00;
        2:       v = 8'h01;
        default: v = 8'($urandom);
      endcase
      mem_imm[i] = v[7:4];
      mem_op[i]  = v[3:0];
    end
  endtask

  // Reference: header, 16 memory bytes, then their sum mod 256.
  task automatic push_exp();
    int sum = 0;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({mem_imm[i], mem_op[i]});
      sum += {mem_imm[i], mem_op[i]};
    end
    exp_q.push_back(8'(sum % 256));
  endtask

  task automatic wait_done(output bit ok);
    int guard = 0;
    while (bus.done !== 1'b1 && guard < int'(DumpCycles) + 50) begin
      step();
      guard++;
    end
    ok = (bus.done === 1'b1);
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rx(input int target);
    int guard = 0;
    while (rx_n < target && guard < int'(DumpCycles) + 50) begin
      step();
      guard++;
    end
    if (rx_n < target) chk("rx_timeout", 32'(rx_n), 32'(target));
  endtask

  task automatic run_dump(input bit hdr_check);
    int         base;
    int         n0;
    bit         ok;
    bit         hdr_ok;
    logic [7:0] hdr;
    logic       want;
    push_exp();
    base      = rx_n;
    n0        = cyc;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("busy_rise", {31'b0, bus.busy}, 32'd1);
    if (hdr_check) begin
      hdr    = 8'hA5;
      hdr_ok = 1'b1;
      for (int k = 0; k < int'(10 * C); k++) begin
        if (k / C == 0)      want = 1'b0;
        else if (k / C == 9) want = 1'b1;
        else                 want = hdr[k / C - 1];
        if (bus.tx !== want) hdr_ok = 1'b0;
        step();
      end
      chk("hdr_frame", {31'b0, hdr_ok}, 32'd1);
      chk("gap_after_hdr", {31'b0, bus.tx}, 32'd1);
    end
    wait_done(ok);
    if (ok) chk("done_latency", 32'(cyc - n0), 32'(DumpCycles));
    chk("byte_count", 32'(rx_n - base), 32'd18);
    step();
  endtask

  initial begin
    bit ok;
    bit bad;
    int base;
    int n0;
    int dc;

    load_mem(1);
    rst       = 1'b1;
    bus.start = 1'b1;

    // Reset with start held: outputs stay idle.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tx",   {31'b0, bus.tx},   32'd1);
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_done", {31'b0, bus.done}, 32'd0);
      chk("rst_addr", {28'b0, bus.mem_address}, 32'd0);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    bad       = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad = 1'b1;
    end
    chk("idle_after_rst", {31'b0, bad}, 32'd0);

    // Ramp memory with header framing and exact completion latency.
    load_mem(0);
    run_dump(1'b1);

    load_mem(1);
    run_dump(1'b0);
    load_mem(2);
    run_dump(1'b0);
    for (int r = 0; r < 3; r++) begin
      load_mem(3);
      repeat ($urandom_range(1, 5)) step();
      run_dump(1'b0);
    end

    // Start pulsed during byte 5 and during the FINISH cycle is ignored.
    load_mem(3);
    push_exp();
    base      = rx_n;
    n0        = cyc;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_rx(base + 5);
    repeat (3 * C) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(ok);
    if (ok) begin
      chk("done_latency_ign", 32'(cyc - n0), 32'(DumpCycles));
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy !== 1'b0) bad = 1'b1;
      step();
    end
    chk("no_restart", {31'b0, bad}, 32'd0);
    chk("byte_count_ign", 32'(rx_n - base), 32'd18);

    // Start held high: second dump starts two cycles after done.
    load_mem(3);
    push_exp();
    push_exp();
    base      = rx_n;
    bus.start = 1'b1;
    step();
    wait_done(ok);
    dc = cyc;
    step();
    chk("held_idle_gap", {31'b0, bus.busy}, 32'd0);
    step();
    chk("held_restart", 32'(cyc - dc), 32'd2);
    chk("held_busy", {31'b0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    wait_done(ok);
    chk("byte_count_held", 32'(rx_n - base), 32'd36);
    step();

    // Reset in the middle of byte 7, then a clean dump.
    load_mem(3);
    push_exp();
    base      = rx_n;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_rx(base + 7);
    for (int g = 0; g < 20 && bus.tx !== 1'b0; g++) step();
    repeat (3 * C) step();
    rst = 1'b1;
    step();
    chk("mid_rst_tx",   {31'b0, bus.tx},   32'd1);
    chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("mid_rst_done", {31'b0, bus.done}, 32'd0);
    chk("mid_rst_addr", {28'b0, bus.mem_address}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    step();
    step();
    load_mem(3);
    run_dump(1'b0);

    repeat (10) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/td4_mem_dump_tx.md
# td4_mem_dump_tx

Serial program-memory dumper for the TD4 tile: on request it walks all 16 program-memory addresses, reads each opcode/immediate pair through the memory read port, and transmits the image over a single-wire UART-style line (8N1, LSB first). It is the read-out counterpart of the pin-driven load path, letting a host verify a loaded program without stepping read mode by hand. It sits beside the CPU and takes the memory address mux while `busy` is high.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range 2..4096.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `start`  input  1  request a dump; sampled only in IDLE.
- `mem_address`  output  4  program-memory read address.
- `opcode_in`  input  4  memory opcode output; combinational read of `mem_address`.
- `immediate_in`  input  4  memory immediate output; combinational read of `mem_address`.
- `tx`  output  1  serial line, idle high.
- `busy`  output  1  high from the cycle after `start` is accepted until `done`.
- `done`  output  1  one-cycle pulse when a dump completes.

## Operation

- Frame sequence per dump: header 0xA5, then memory bytes for addresses 0..15, then checksum. Total 18 bytes.
- Memory byte is {immediate_in, opcode_in}: immediate in bits [7:4], opcode in bits [3:0].
- Checksum is the sum of the 16 memory bytes mod 256. The header is excluded. An 8-bit accumulator is cleared on start.
- Each byte is sent as a start bit (0), data bits 0..7, then a stop bit (1). Every bit is held exactly `CLKS_PER_BIT` cycles.
- FSM states:
  - IDLE: `tx`=1, `busy`=0. On `start`, load the header into the shift register and go to START.
  - START, DATA, STOP: bit phases; a 3-bit index counts the data bits.
  - STOP exit:
    - go to FETCH if the next byte is a memory byte;
    - go to LOADCK if the next byte is the checksum;
    - go to FINISH after the checksum frame.
  - FETCH: drive `mem_address`; `tx`=1.
  - LOAD: latch {immediate_in, opcode_in} into the shift register and add it to the accumulator; `tx`=1. Go to START.
  - LOADCK: idle gap before the checksum. Latch the accumulator in the second gap cycle so the inter-frame gap is the same as for memory bytes.
  - FINISH: pulse `done`, then return to IDLE.
- Address counter: 0..15. It increments after each LOAD and is held at 0 outside a dump.
- Address 15 is followed by the checksum; the counter does not wrap into another memory fetch.
- `start` while `busy`: ignored. No queuing.
- `start` high in the FINISH cycle: ignored. It is accepted the next cycle if it is still high.
- `rst` mid-operation:
  - the next cycle shows the full reset state;
  - any partial frame is truncated, with `tx` high;
  - the accumulator and counters are cleared.

## Timing

- Reset values: `tx`=1, `busy`=0, `done`=0, `mem_address`=0. All internal counters are 0 and the FSM is in IDLE.
- `start` sampled high in IDLE at cycle N:
  - `busy`=1 and the header start bit (`tx`=0) begin at N+1;
  - the header occupies N+1 .. N+10·C, where C=`CLKS_PER_BIT`.
- Every later byte is preceded by exactly 2 idle-high gap cycles (FETCH+LOAD, or the LOADCK pair). Each byte then takes 10·C cycles.
- The last stop bit ends at N+180·C+34. In the next cycle, N+180·C+35, `done`=1 and `busy`=0.
- IDLE is at N+180·C+36.
- `mem_address` is stable for the whole FETCH and LOAD pair. Memory data is sampled at the end of LOAD, one cycle after the address is presented.
- All outputs are registered, with no combinational path from an input to `tx`.

## Test plan

- Reset: hold `rst` 3 cycles, with `start` also high -> `tx`=1, `busy`=0, `done`=0, `mem_address`=0 throughout; no frame appears.
- Header framing, C=4, `start` at cycle 10 -> `tx` low for cycles 11–14, then bits of 0xA5 LSB first (1,0,1,0,0,1,0,1), 4 cycles each; stop high at cycles 47–50.
- Ramp memory (addr i holds 0x11·i), C=4 -> decoded bytes are A5, 00, 11, …, FF, F8. `done` pulses exactly 755 cycles after `start`, and `busy` falls in the same cycle.
- All-zero memory -> checksum byte 0x00. Memory holding 0x01 everywhere -> checksum 0x10.
- `start` pulsed during byte 5 and during the FINISH cycle -> no effect; exactly 18 bytes are sent. `start` held high -> a second dump begins 2 cycles after `done`.
- `rst` asserted mid data bit of byte 7 -> `tx`=1 and `busy`=0 next cycle. A fresh `start` then produces a full dump with the correct checksum (the accumulator was cleared).
